// File: rtl/imm_pkg.sv
// Shared definitions for the RV64I immediate generator: format codes,
// major opcode constants and datapath width.
package imm_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

endpackage

// File: rtl/immediate_gen_if.sv
// Instruction-in / immediate-out bundle for the immediate generator,
// carrying both the combinational and the registered results.
interface immediate_gen_if;
  import imm_pkg::*;

  logic [31:0]     instr;
  logic [XLEN-1:0] imm;
  imm_fmt_t        fmt;
  logic [XLEN-1:0] imm_q;
  imm_fmt_t        fmt_q;
  logic            valid_q;

  modport master (
    output instr,
    input  imm, fmt, imm_q, fmt_q, valid_q
  );

  modport slave (
    input  instr,
    output imm, fmt, imm_q, fmt_q, valid_q
  );
endinterface

// File: rtl/imm_fmt_decode.sv
// Opcode to immediate-format classifier; purely combinational so the
// main control unit can reuse it without timing impact.
module imm_fmt_decode
  import imm_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_fmt_t   fmt
);

  // Map each major opcode to its immediate layout; unknown opcodes carry none.
  always_comb begin
    fmt = IMM_NONE;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                                     fmt = IMM_S;
      OPC_BRANCH:                                    fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:                            fmt = IMM_U;
      OPC_JAL:                                       fmt = IMM_J;
      default:                                       fmt = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/immediate_gen.sv
// RV64I immediate generator: combinational sign-extended immediate for the
// single-cycle datapath plus a one-cycle registered copy with format tag.
module immediate_gen
  import imm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  immediate_gen_if.slave   bus
);

  logic [31:0]     instr_s;
  imm_fmt_t        fmt_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_r;
  imm_fmt_t        fmt_r;
  logic            valid_r;

  assign instr_s = bus.instr;

  imm_fmt_decode u_fmt_decode (
    .opcode (instr_s[6:0]),
    .fmt    (fmt_s)
  );

  // Per-format bit gather; every layout sign-extends from instr[31].
  always_comb begin
    imm_s = {XLEN{1'b0}};
    case (fmt_s)
      IMM_I: imm_s = {{52{instr_s[31]}}, instr_s[31:20]};
      IMM_S: imm_s = {{52{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
      IMM_B: imm_s = {{51{instr_s[31]}}, instr_s[31], instr_s[7],
                      instr_s[30:25], instr_s[11:8], 1'b0};
      IMM_U: imm_s = {{32{instr_s[31]}}, instr_s[31:12], 12'd0};
      IMM_J: imm_s = {{43{instr_s[31]}}, instr_s[31], instr_s[19:12],
                      instr_s[20], instr_s[30:21], 1'b0};
      default: imm_s = {XLEN{1'b0}};
    endcase
  end

  // Unconditional capture each cycle; reset clears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_r   <= {XLEN{1'b0}};
      fmt_r   <= IMM_NONE;
      valid_r <= 1'b0;
    end else begin
      imm_r   <= imm_s;
      fmt_r   <= fmt_s;
      valid_r <= (fmt_s != IMM_NONE);
    end
  end

  assign bus.imm     = imm_s;
  assign bus.fmt     = fmt_s;
  assign bus.imm_q   = imm_r;
  assign bus.fmt_q   = fmt_r;
  assign bus.valid_q = valid_r;

endmodule

// File: tb/tb_immediate_gen.sv
// Self-checking bench for immediate_gen: directed vectors, register stage,
// reset behaviour and randomized instructions against an arithmetic model.
module tb_immediate_gen;
  import imm_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  immediate_gen_if bus ();

  immediate_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] model_fmt(input logic [31:0] w);
    int op;
    op = int'(w & 32'd127);
    case (op)
      3, 19, 27, 103: return 3'd1;
      35:             return 3'd2;
      99:             return 3'd3;
      55, 23:         return 3'd4;
      111:            return 3'd5;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_imm(input logic [31:0] w);
    longint u;
    longint v;
    u = longint'({32'd0, w});
    v = 0;
    case (model_fmt(w))
      3'd1: begin
        v = u >> 20;
        if (v >= 2048) v = v - 4096;
      end
      3'd2: begin
        v = ((u >> 25) * 32) + ((u >> 7) % 32);
        if (v >= 2048) v = v - 4096;
      end
      3'd3: begin
        v = ((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048
          + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2;
        if (v >= 4096) v = v - 8192;
      end
      3'd4: begin
        v = (u >> 12) * 4096;
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
      end
      3'd5: begin
        v = ((u >> 31) % 2) * 1048576 + ((u >> 12) % 256) * 4096
          + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.imm_q !== 64'd0 || bus.fmt_q !== IMM_NONE || bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: imm_q=%h fmt_q=%0d valid_q=%b expected 0/0/0",
               bus.imm_q, bus.fmt_q, bus.valid_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vec_instr [0:9];
    logic [63:0] vec_imm   [0:9];
    logic [2:0]  vec_fmt   [0:9];
    vec_instr[0] = 32'h00A00093; vec_imm[0] = 64'd10;                 vec_fmt[0] = 3'd1;
    vec_instr[1] = 32'hFFB00093; vec_imm[1] = 64'hFFFFFFFFFFFFFFFB;   vec_fmt[1] = 3'd1;
    vec_instr[2] = 32'h00303823; vec_imm[2] = 64'd16;                 vec_fmt[2] = 3'd2;
    vec_instr[3] = 32'h00208463; vec_imm[3] = 64'd8;                  vec_fmt[3] = 3'd3;
    vec_instr[4] = 32'hFE000CE3; vec_imm[4] = 64'hFFFFFFFFFFFFFFF8;   vec_fmt[4] = 3'd3;
    vec_instr[5] = 32'h123450B7; vec_imm[5] = 64'h0000000012345000;   vec_fmt[5] = 3'd4;
    vec_instr[6] = 32'h800000B7; vec_imm[6] = 64'hFFFFFFFF80000000;   vec_fmt[6] = 3'd4;
    vec_instr[7] = 32'hFFDFF06F; vec_imm[7] = 64'hFFFFFFFFFFFFFFFC;   vec_fmt[7] = 3'd5;
    vec_instr[8] = 32'hFFFFFFFF; vec_imm[8] = 64'd0;                  vec_fmt[8] = 3'd0;
    vec_instr[9] = 32'h00000033; vec_imm[9] = 64'd0;                  vec_fmt[9] = 3'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.instr = vec_instr[i];
      #1;
      n_checks++;
      if (bus.imm !== vec_imm[i] || bus.fmt !== vec_fmt[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: instr=%h imm=%h fmt=%0d expected imm=%h fmt=%0d",
                 i, vec_instr[i], bus.imm, bus.fmt, vec_imm[i], vec_fmt[i]);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.imm_q !== vec_imm[i] || bus.fmt_q !== vec_fmt[i]
          || bus.valid_q !== (vec_fmt[i] != 3'd0)) begin
        n_fail++;
        $display("FAIL directed_q_%0d: imm_q=%h fmt_q=%0d valid_q=%b expected %h/%0d/%b",
                 i, bus.imm_q, bus.fmt_q, bus.valid_q, vec_imm[i], vec_fmt[i],
                 (vec_fmt[i] != 3'd0));
      end
    end
  endtask

  task automatic test_register();
    @(negedge clk);
    bus.instr = 32'h00A00093;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.imm_q !== 64'd10 || bus.fmt_q !== IMM_I || bus.valid_q !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_capture: imm_q=%h fmt_q=%0d valid_q=%b expected 10/1/1",
               bus.imm_q, bus.fmt_q, bus.valid_q);
    end
    @(negedge clk);
    bus.instr = 32'h123450B7;
    #1;
    n_checks++;
    if (bus.imm_q !== 64'd10 || bus.fmt_q !== IMM_I) begin
      n_fail++;
      $display("FAIL reg_hold: imm_q=%h fmt_q=%0d expected 10/1 before edge",
               bus.imm_q, bus.fmt_q);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.imm_q !== 64'h0000000012345000 || bus.fmt_q !== IMM_U) begin
      n_fail++;
      $display("FAIL reg_update: imm_q=%h fmt_q=%0d expected 12345000/4",
               bus.imm_q, bus.fmt_q);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    bus.instr = 32'hFFB00093;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.imm_q !== 64'd0 || bus.fmt_q !== IMM_NONE || bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: imm_q=%h fmt_q=%0d valid_q=%b expected 0/0/0",
               bus.imm_q, bus.fmt_q, bus.valid_q);
    end
    bus.instr = 32'hFFDFF06F;
    #1;
    n_checks++;
    if (bus.imm !== 64'hFFFFFFFFFFFFFFFC || bus.fmt !== IMM_J) begin
      n_fail++;
      $display("FAIL reset_comb_track: imm=%h fmt=%0d expected fffffffffffffffc/5",
               bus.imm, bus.fmt);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.imm_q !== 64'd0 || bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_edge: imm_q=%h valid_q=%b expected 0/0",
               bus.imm_q, bus.valid_q);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.imm_q !== 64'd0 || bus.valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_noedge: imm_q=%h valid_q=%b expected 0/0",
               bus.imm_q, bus.valid_q);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.imm_q !== 64'hFFFFFFFFFFFFFFFC || bus.fmt_q !== IMM_J || bus.valid_q !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_resume: imm_q=%h fmt_q=%0d valid_q=%b expected fffffffffffffffc/5/1",
               bus.imm_q, bus.fmt_q, bus.valid_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  opc_tab [0:9];
    logic [31:0] w;
    logic [31:0] prev;
    logic [6:0]  opc;
    opc_tab[0] = 7'b0000011; opc_tab[1] = 7'b0010011; opc_tab[2] = 7'b0011011;
    opc_tab[3] = 7'b1100111; opc_tab[4] = 7'b0100011; opc_tab[5] = 7'b1100011;
    opc_tab[6] = 7'b0110111; opc_tab[7] = 7'b0010111; opc_tab[8] = 7'b1101111;
    opc_tab[9] = 7'b0110011;
    prev = bus.instr;
    for (int i = 0; i < 400; i++) begin
      w = $urandom();
      if ($urandom_range(0, 4) != 0) begin
        opc = opc_tab[$urandom_range(0, 9)];
        w = {w[31:7], opc};
      end
      @(negedge clk);
      bus.instr = w;
      #1;
      n_checks++;
      if (bus.imm !== model_imm(w) || bus.fmt !== model_fmt(w)) begin
        n_fail++;
        $display("FAIL random_comb: instr=%h imm=%h fmt=%0d expected imm=%h fmt=%0d",
                 w, bus.imm, bus.fmt, model_imm(w), model_fmt(w));
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.imm_q !== model_imm(w) || bus.fmt_q !== model_fmt(w)
          || bus.valid_q !== (model_fmt(w) != 3'd0)) begin
        n_fail++;
        $display("FAIL random_reg: instr=%h prev=%h imm_q=%h fmt_q=%0d valid_q=%b expected %h/%0d",
                 w, prev, bus.imm_q, bus.fmt_q, bus.valid_q, model_imm(w), model_fmt(w));
      end
      prev = w;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.instr = 32'h00A00093;
    test_reset();
    test_directed();
    test_register();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
